// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program memory with boot-time clear, bus MAR/read/write and direct programming port
// Three-state controller: BOOT clears every word, RUN serves the shared bus, PROG accepts direct writes.
module prog_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              lm_n,
    input  logic              ce_n,
    input  logic              we_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              ready,
    output logic [ADDR_W-1:0] mar
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PROG
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt wraps back to zero on the last clear write, ready for the next boot
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (state == BOOT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar <= '0;
        end else if (state == RUN && !lm_n) begin
            mar <= bus_in[ADDR_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_addr  = mar;
        mem_wdata = bus_in;
        case (state)
            BOOT: begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
                if (&cnt) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mem_we = !we_n;
                if (prog_en) begin
                    state_nxt = PROG;
                end
            end
            PROG: begin
                // a strobe on the exit edge (prog_en already low) is dropped
                mem_we    = prog_we && prog_en;
                mem_addr  = prog_addr;
                mem_wdata = prog_data;
                if (!prog_en) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // clr_n gating keeps memory untouched by edges that arrive while reset is held
    always_ff @(posedge clk) begin
        if (mem_we && clr_n) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign ready   = (state == RUN);
    assign bus_oe  = ready && !ce_n;
    assign bus_out = bus_oe ? mem[mar] : '0;

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits; legal only when DATA_W >= ADDR_W.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; depth = 2**ADDR_W words.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr_n  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port lm_n  in  1  active-low MAR load; MAR <= bus_in[ADDR_W-1:0].
REQ-006 The block SHALL have port ce_n  in  1  active-low read enable onto the bus.
REQ-007 The block SHALL have port we_n  in  1  active-low bus write; mem[MAR] <= bus_in.
REQ-008 The block SHALL have port bus_in  in  DATA_W  bus data into the block.
REQ-009 The block SHALL have port bus_out  out  DATA_W  read data; zero when bus_oe=0.
REQ-010 The block SHALL have port bus_oe  out  1  bus drive enable; the top level uses it to gate the shared bus.
REQ-011 The block SHALL have port prog_en  in  1  request for programming mode.
REQ-012 The block SHALL have port prog_we  in  1  programming write strobe.
REQ-013 The block SHALL have port prog_addr  in  ADDR_W  programming address.
REQ-014 The block SHALL have port prog_data  in  DATA_W  programming data.
REQ-015 The block SHALL have port ready  out  1  high only in state RUN.
REQ-016 The block SHALL have port mar  out  ADDR_W  current memory address register value.

Function
REQ-017 The FSM SHALL have exactly 3 states, BOOT, RUN and PROG, with BOOT entered on reset.
REQ-018 In BOOT, the FSM SHALL write 0 to mem[cnt] once per cycle, with cnt running 0..2**ADDR_W-1.
REQ-019 After the write of the last address in BOOT, the FSM SHALL go to RUN on the next edge; BOOT therefore lasts exactly 2**ADDR_W cycles.
REQ-020 In BOOT, the block SHALL ignore lm_n, we_n, ce_n, prog_en and prog_we.
REQ-021 In RUN, the FSM SHALL go to PROG at an edge where prog_en=1; otherwise it SHALL stay in RUN.
REQ-022 In PROG, the FSM SHALL return to RUN at an edge where prog_en=0.
REQ-023 In PROG, prog_we=1 at an edge SHALL write mem[prog_addr] <= prog_data, one word per cycle with no throttling.
REQ-024 In PROG, the block SHALL ignore lm_n, we_n and ce_n, and SHALL hold bus_oe=0.
REQ-025 A prog_we that coincides with the RUN->PROG edge SHALL be ignored.
REQ-026 A prog_we that coincides with the PROG->RUN edge (prog_en=0) SHALL be ignored.
REQ-027 In RUN, lm_n=0 at an edge SHALL load MAR from bus_in[ADDR_W-1:0]; upper bits SHALL be ignored.
REQ-028 In RUN, we_n=0 at an edge SHALL write bus_in to mem[MAR].
REQ-029 When lm_n=0 and we_n=0 at the same edge, the write SHALL use the pre-edge MAR value.
REQ-030 bus_oe SHALL equal ready AND NOT ce_n, evaluated combinationally.
REQ-031 bus_out SHALL equal mem[MAR] when bus_oe=1 and zero otherwise, with no added latency.
REQ-032 When ce_n=0 and we_n=0 together, bus_out SHALL show the old word until the edge and the new word after it.
REQ-033 MAR SHALL wrap naturally within ADDR_W bits; no address beyond depth SHALL exist.
REQ-034 When prog_en=1 at the edge BOOT->RUN, the FSM SHALL enter RUN and then go to PROG on the following edge.

Reset
REQ-035 clr_n=0 SHALL force, immediately and without waiting for clk, state=BOOT, cnt=0, MAR=0, ready=0, bus_oe=0 and bus_out=0.
REQ-036 Memory contents SHALL NOT be reset asynchronously; they are cleared by the BOOT sequence.
REQ-037 A reset asserted mid-BOOT, mid-PROG or mid-write SHALL abort the operation and restart BOOT from cnt=0 after release.
REQ-038 The first clear write SHALL occur at the first rising edge after clr_n=1.

Verification
REQ-039 Boot test: release reset with defaults -> ready=0 for 16 edges and 1 after the 16th; every address then reads 0x00.
REQ-040 Program-and-read test: prog_en=1, write 0x0A@0, 0x17@1, 0xE4@2, drop prog_en, load MAR=1, ce_n=0 -> bus_oe=1, bus_out=0x17.
REQ-041 Bus write test: in RUN, bus_in=0x3C with lm_n=0 and we_n=0 while MAR=5 -> mem[5]=0x3C; MAR becomes 0xC (low nibble of 0x3C); mem[0xC] unchanged.
REQ-042 Gating test: in PROG with ce_n=0, lm_n=0, we_n=0 -> bus_oe=0, bus_out=0, MAR and memory unchanged except by prog_we.
REQ-043 Reset-mid-operation test: assert clr_n=0 at boot cycle 7 -> outputs zero at once; after release the full 16-cycle BOOT is repeated.
REQ-044 Parameter test: DATA_W=12, ADDR_W=6 -> 64-cycle boot; write 0xABC@63 in PROG and read back 0xABC through MAR=63.
